// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with dead-time,
// per-frame input snapshot and leading-zero blanking.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 2,
    parameter int REFRESH_DIV    = 24000,
    parameter int DEAD_CYCLES    = 48,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b0,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    en,
    output logic [6:0]              segs,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] snap_val, snap_val_nx;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nx;
    logic                    en_q, blz_q;

    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_run;
    logic                    on_nx;
    logic [3:0]              digit;
    logic [6:0]              pattern;
    logic [6:0]              segs_nx;
    logic                    dp_nx;
    logic [NUM_DIGITS-1:0]   digit_en_nx;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        p = 7'h00;
        case (d)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h67;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            4'hF: p = 7'h71;
        endcase
        return p;
    endfunction

    // Slot counter, digit index and frame snapshot
    always_comb begin
        cnt_nx      = cnt + 1'b1;
        idx_nx      = idx;
        snap_val_nx = snap_val;
        snap_dp_nx  = snap_dp;
        if (cnt == CNT_LAST) begin
            cnt_nx = '0;
            if (idx == IDX_LAST) begin
                idx_nx      = '0;
                snap_val_nx = value;
                snap_dp_nx  = dp_in;
            end else begin
                idx_nx = idx + 1'b1;
            end
        end
    end

    // Digit i is blank when it and every digit above it are zero
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (snap_val_nx[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run & blz_q;
        end
    end

    always_comb begin
        on_nx       = 32'(cnt_nx) >= DEAD_CYCLES;
        digit       = snap_val_nx[4*idx_nx +: 4];
        pattern     = decode(digit);
        segs_nx     = SEG_OFF;
        dp_nx       = SEG_ACTIVE_LOW;
        digit_en_nx = EN_OFF;
        if (on_nx && en_q) begin
            digit_en_nx = (NUM_DIGITS'(1) << idx_nx) ^ EN_OFF;
            dp_nx       = snap_dp_nx[idx_nx] ^ SEG_ACTIVE_LOW;
            if (!blank_mask[idx_nx]) begin
                segs_nx = pattern ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            snap_val  <= '0;
            snap_dp   <= '0;
            en_q      <= 1'b0;
            blz_q     <= 1'b0;
            segs      <= SEG_OFF;
            dp        <= SEG_ACTIVE_LOW;
            digit_en  <= EN_OFF;
            digit_idx <= '0;
        end else begin
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            snap_val  <= snap_val_nx;
            snap_dp   <= snap_dp_nx;
            en_q      <= en;
            blz_q     <= blank_lz;
            segs      <= segs_nx;
            dp        <= dp_nx;
            digit_en  <= digit_en_nx;
            digit_idx <= idx_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a 4-digit scan instance and a
// single-digit instance with inverted polarities.
module tb_seg_scan_driver;

    typedef struct {
        int         at;
        logic [3:0] den;
        logic [6:0] segs;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] value_a;
    logic [3:0]  dp_a;
    logic        blz;
    logic        en;
    logic [6:0]  segs_a;
    logic        dp_out_a;
    logic [3:0]  den_a;
    logic [1:0]  idx_a;

    logic [3:0]  value_b;
    logic [0:0]  dp_b;
    logic        blz_b;
    logic        en_b;
    logic [6:0]  segs_b;
    logic        dp_out_b;
    logic [0:0]  den_b;
    logic [0:0]  idx_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   ticks  = 0;
    bit   done   = 1'b0;

    seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)
    ) dut_a (
        .clk(clk), .reset(rst), .value(value_a), .dp_in(dp_a),
        .blank_lz(blz), .en(en), .segs(segs_a), .dp(dp_out_a),
        .digit_en(den_a), .digit_idx(idx_a)
    );

    seg_scan_driver #(
        .NUM_DIGITS(1), .REFRESH_DIV(8), .DEAD_CYCLES(2),
        .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset(rst), .value(value_b), .dp_in(dp_b),
        .blank_lz(blz_b), .en(en_b), .segs(segs_b), .dp(dp_out_b),
        .digit_en(den_b), .digit_idx(idx_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge count since reset release equals the scan position
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic push_reset();
        exp_t e;
        e.at = 0; e.den = 4'b0000; e.segs = 7'h7F; e.dp = 1'b1; e.idx = 2'd0;
        qa.push_back(e);
        e.den = 4'b0001; e.segs = 7'h00; e.dp = 1'b0;
        qb.push_back(e);
    endtask

    // Expected 4-digit scan: p0..p3 are active-low segment images per digit
    task automatic span_a(input int from, input int to,
                          input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [6:0] p3,
                          input logic [3:0] dpm,
                          input int off_from, input int off_to);
        logic [6:0] pt [4];
        exp_t e;
        int c;
        int s;
        pt[0] = p0; pt[1] = p1; pt[2] = p2; pt[3] = p3;
        for (int k = from; k <= to; k++) begin
            c = k % 8;
            s = (k / 8) % 4;
            e.at  = k;
            e.idx = 2'(s);
            if (c < 2 || (k >= off_from && k <= off_to)) begin
                e.den = 4'b0000; e.segs = 7'h7F; e.dp = 1'b1;
            end else begin
                e.den  = 4'b0001 << s;
                e.segs = pt[s];
                e.dp   = ~dpm[s];
            end
            qa.push_back(e);
        end
    endtask

    // Single digit showing 8, active-high segments, active-low enable
    task automatic span_b(input int from, input int to);
        exp_t e;
        for (int k = from; k <= to; k++) begin
            e.at = k; e.idx = 2'd0; e.dp = 1'b0;
            if (k % 8 < 2) begin
                e.den = 4'b0001; e.segs = 7'h00;
            end else begin
                e.den = 4'b0000; e.segs = 7'h7F;
            end
            qb.push_back(e);
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ticks++;
        while (qa.size() > 0 && qa[0].at <= edge_n) begin
            ea = qa.pop_front();
            checks++;
            if (ea.at != edge_n) begin
                errors++;
                $display("FAIL a_missed want_edge=%0d now=%0d", ea.at, edge_n);
            end else if ({den_a, segs_a, dp_out_a, idx_a} !==
                         {ea.den, ea.segs, ea.dp, ea.idx}) begin
                errors++;
                $display("FAIL a_out edge=%0d got den=%b segs=%h dp=%b idx=%0d want den=%b segs=%h dp=%b idx=%0d",
                         edge_n, den_a, segs_a, dp_out_a, idx_a,
                         ea.den, ea.segs, ea.dp, ea.idx);
            end
        end
        while (qb.size() > 0 && qb[0].at <= edge_n) begin
            eb = qb.pop_front();
            checks++;
            if (eb.at != edge_n) begin
                errors++;
                $display("FAIL b_missed want_edge=%0d now=%0d", eb.at, edge_n);
            end else if ({den_b, segs_b, dp_out_b, idx_b} !==
                         {eb.den[0], eb.segs, eb.dp, eb.idx[0]}) begin
                errors++;
                $display("FAIL b_out edge=%0d got den=%b segs=%h dp=%b idx=%0d want den=%b segs=%h dp=%b idx=%0d",
                         edge_n, den_b, segs_b, dp_out_b, idx_b,
                         eb.den[0], eb.segs, eb.dp, eb.idx[0]);
            end
        end
        if (done || ticks > 3000) begin
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL timeout ticks=%0d limit=3000", ticks);
            end
            checks++;
            if (qa.size() != 0 || qb.size() != 0) begin
                errors++;
                $display("FAIL leftover got a=%0d b=%0d want 0 0",
                         qa.size(), qb.size());
            end
            $display("Simulation finished: %0d checks, %0d errors",
                     checks, errors);
            $finish;
        end
    end

    initial begin
        rst     = 1'b1;
        value_a = 16'h12AF;
        dp_a    = 4'b0100;
        blz     = 1'b0;
        en      = 1'b1;
        value_b = 4'h8;
        dp_b    = 1'b0;
        blz_b   = 1'b0;
        en_b    = 1'b1;
        push_reset();
        span_a(32, 95, 7'h0E, 7'h08, 7'h24, 7'h79, 4'b0100, -1, -1);
        span_b(8, 40);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        wait_edge(70);
        value_a = 16'h1111;
        dp_a    = 4'b0000;
        span_a(96, 127, 7'h79, 7'h79, 7'h79, 7'h79, 4'b0000, -1, -1);
        wait_edge(106);
        value_a = 16'h2222;
        span_a(128, 159, 7'h24, 7'h24, 7'h24, 7'h24, 4'b0000, -1, -1);

        wait_edge(130);
        blz     = 1'b1;
        value_a = 16'h0040;
        span_a(160, 191, 7'h40, 7'h19, 7'h7F, 7'h7F, 4'b0000, -1, -1);
        wait_edge(170);
        value_a = 16'h0000;
        span_a(192, 223, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, -1, -1);
        span_a(224, 255, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, -1, -1);
        wait_edge(226);
        blz = 1'b0;

        span_a(256, 300, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 262, 281);
        wait_edge(260);
        en = 1'b0;
        wait_edge(280);
        en = 1'b1;

        wait_edge(309);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 push_reset();
        @(negedge clk);
        span_a(1, 40, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, -1, -1);
        span_b(8, 24);
        #2 rst = 1'b0;

        wait_edge(41);
        @(negedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits that share one segment bus. It takes a packed hex value plus per-digit decimal points and scans the digits round-robin at a programmable refresh rate. It adds dead-time between digits to suppress ghosting, latches the input once per frame so a displayed frame never mixes old and new digits, and can blank leading zeros. It sits between core logic and the board pins and takes over from the single-digit combinational hex decoder.

## Interface
- NUM_DIGITS, 2: number of multiplexed digits; must be ≥1.
- REFRESH_DIV, 24000: clock cycles per digit slot (2 kHz per slot at 48 MHz); must be ≥ DEAD_CYCLES+1.
- DEAD_CYCLES, 48: cycles at the start of each slot with all digits off.
- SEG_ACTIVE_LOW, 1: 1 means segment/dp outputs drive 0 to light.
- EN_ACTIVE_LOW, 0: 1 means digit enables drive 0 to select.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex digits; [3:0] is digit 0, the least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_lz  in  1  leading-zero blanking enable.
- en  in  1  display enable.
- segs  out  7  segment drive, bit 0 = a … bit 6 = g.
- dp  out  1  decimal-point drive.
- digit_en  out  NUM_DIGITS  one-hot digit select, in EN_ACTIVE_LOW polarity.
- digit_idx  out  max(1,$clog2(NUM_DIGITS))  index of the current slot.

## Operation
- Registers:
  - cnt: 0..REFRESH_DIV-1.
  - idx: 0..NUM_DIGITS-1.
  - snap_val, snap_dp: frame snapshot.
  - en_q, blz_q: en and blank_lz sampled every cycle.
- Slot state:
  - DEAD while cnt < DEAD_CYCLES.
  - ON otherwise.
- Counter and index advance:
  - cnt increments every cycle.
  - At cnt = REFRESH_DIV-1, cnt goes to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - On the edge where idx wraps to 0, snap_val ← value and snap_dp ← dp_in.
  - Nothing else updates the snapshot.
- Decode table (active-high pattern, segment a in bit 0), keyed on the 4-bit digit value:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, b:7C, C:39, d:5E, E:79, F:71
- Leading-zero blanking:
  - With blz_q=1, digit i is blanked if snap_val digits NUM_DIGITS-1..i are all 0.
  - Digit 0 is never blanked.
  - A blanked digit shows segs off and dp = snap_dp[i].
- Digit select:
  - The lit digit is digit idx, only in ON, only when en_q=1.
  - Otherwise all digit_en are inactive and segs/dp are off.
- Polarity:
  - segs and dp are XORed with SEG_ACTIVE_LOW.
  - digit_en is XORed with EN_ACTIVE_LOW.
- Reset state:
  - cnt=0, idx=0, snapshot=0, en_q=0, blz_q=0.
  - All outputs inactive: segs=7'h7F, dp=1 and digit_en=0 with default parameters.
  - digit_idx=0.
- Reset asserted mid-slot returns everything to the reset state immediately (asynchronous). The scan restarts at slot 0 with cnt=0.

## Timing
- digit_en, segs, dp and digit_idx are registers loaded from next-state values. In every cycle they match the current cnt/idx/snapshot/en_q. There is no combinational path from inputs to outputs.
- Slot length:
  - Digit idx is lit for exactly REFRESH_DIV-DEAD_CYCLES consecutive cycles per slot.
  - Every slot begins with DEAD_CYCLES all-off cycles.
  - Two enables are never active in the same cycle.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Latency from inputs:
  - A change to value or dp_in appears on the next frame boundary and never within a frame.
  - A change to en or blank_lz takes effect 2 cycles later (sample register, then output register).
- A simultaneous wrap and en deassertion counts as a normal wrap: the snapshot still loads.
- NUM_DIGITS=1: idx stays 0, the snapshot loads every REFRESH_DIV cycles, and digit_en[0] still observes dead-time.

## Test plan
Unless stated otherwise, these cases use NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, default polarities.
- **Reset:** hold reset, then release with value=16'h12AF, en=1.
  - While in reset: segs=7F, dp=1, digit_en=0, digit_idx=0.
  - After reset asserted asynchronously mid-slot: outputs return to the reset values within the same cycle.
- **Scan order:** value=16'h12AF, dp_in=4'b0100, en=1, after the first frame boundary.
  - Each slot shows 2 cycles all-off, then 6 cycles lit.
  - Per slot: digit_en 0001 with segs=~71 (F), 0010 with ~77 (A), 0100 with ~5B (2) and dp=0, 1000 with ~06 (1).
  - The slot sequence repeats every 32 cycles.
- **Frame coherence:** change value from 16'h1111 to 16'h2222 during slot 1.
  - Slots 2 and 3 still show 1.
  - All four digits show 2 from the next slot 0.
- **Leading-zero blanking:** blank_lz=1.
  - value=16'h0040: digits 3 and 2 show segs=7F, digit 1 shows ~66, digit 0 shows ~3F.
  - value=16'h0000: only digit 0 lit, showing 0.
  - blank_lz=0: all four digits show 0.
- **Enable:** drop en for 20 cycles.
  - digit_en=0 starting 2 cycles after the drop.
  - cnt/idx keep advancing; on re-enable, display resumes at the slot position that elapsed time implies.
- **Polarity and degenerate case:** SEG_ACTIVE_LOW=0, EN_ACTIVE_LOW=1, NUM_DIGITS=1, value=4'h8.
  - segs=7F and digit_en=0 in ON.
  - segs=00 and digit_en=1 in DEAD.
